pmp_scan_ctrl: RTL and testbench
================================

PMP_SCAN_CTRL -- requirements
Module: pmp_scan_ctrl

Interface
REQ-001 SHALL have parameter PMP_ENTRIES, default 16: number of PMP entries scanned; legal range 0..64.
REQ-002 SHALL have parameter PA_BITS, default 56: physical address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ReqValid  input  1  check request present.
REQ-006 SHALL have port ReqReady  output  1  block accepts a request.
REQ-007 SHALL have port PhysicalAddress  input  PA_BITS  address to check; sampled on accept.
REQ-008 SHALL have port PrivilegeMode  input  2  requester privilege (3 = M); sampled on accept.
REQ-009 SHALL have port AccessXWR  input  3  {execute, write, read} request bits; sampled on accept.
REQ-010 SHALL have port PMPCFG_ARRAY_REGW  input  8 x PMP_ENTRIES  per-entry cfg {L,2'b0,A[1:0],X,W,R}.
REQ-011 SHALL have port PMPADDR_ARRAY_REGW  input  (PA_BITS-2) x PMP_ENTRIES  per-entry pmpaddr (PA>>2).
REQ-012 SHALL have port CfgWrite  input  1  a PMP CSR was written this cycle.
REQ-013 SHALL have port RespValid  output  1  result valid.
REQ-014 SHALL have port RespReady  input  1  consumer takes the result.
REQ-015 SHALL have port Fault  output  1  access fault.
REQ-016 SHALL have port MatchFound  output  1  some entry matched.
REQ-017 SHALL have port MatchIdx  output  6  index of first matching entry; 0 when none.

Function
REQ-018 SHALL implement states IDLE, SCAN and RESP; ReqReady = (state==IDLE).
REQ-019 SHALL, on an IDLE cycle with ReqValid, latch the request, clear Idx to 0 and PrevGE to 1, and enter SCAN.
REQ-020 SHALL evaluate exactly one entry (Idx) per SCAN cycle through a single shared address-match datapath.
REQ-021 SHALL decode entry matches from A as follows: OFF never matches; TOR matches when PrevGE && PA < {pmpaddr[Idx],2'b00}; NA4 matches when PA[PA_BITS-1:2]==pmpaddr[Idx]; NAPOT matches on the bits above the trailing-ones mask of pmpaddr, region size 2^(t+3) where t is the trailing-ones count.
REQ-022 SHALL, in each SCAN cycle, register PrevGE <= (PA >= {pmpaddr[Idx],2'b00}) for use as the TOR lower bound of entry Idx+1.
REQ-023 SHALL, on the first match, register MatchFound=1 and MatchIdx=Idx and enter RESP; lower-indexed entries have priority.
REQ-024 SHALL, on a non-matching SCAN cycle with Idx==PMP_ENTRIES-1, register MatchFound=0 and MatchIdx=0 and enter RESP; otherwise Idx increments.
REQ-025 SHALL, when PMP_ENTRIES==0, go from IDLE directly to SCAN-less RESP one cycle after accept, with MatchFound=0.
REQ-026 SHALL compute Enforce = (PrivilegeMode!=3) | (MatchFound & L[MatchIdx]).
REQ-027 SHALL compute Fault = Enforce & |(AccessXWR & ~(MatchFound ? cfg[MatchIdx][2:0] : 3'b000)).
REQ-028 SHALL never fault an AccessXWR==0 request.
REQ-029 SHALL set latency from accept edge to the RespValid-high edge to k+1 edges for first match k, and PMP_ENTRIES edges for no match.
REQ-030 SHALL assert RespValid only in RESP and hold RespValid, Fault, MatchFound and MatchIdx stable until RespReady.
REQ-031 SHALL return to IDLE on a RESP cycle with RespReady; the next request is accepted no earlier than the following cycle.
REQ-032 SHALL, on CfgWrite in SCAN, restart the scan: Idx=0, PrevGE=1, request retained.
REQ-033 SHALL ignore CfgWrite in IDLE and RESP; a delivered result is never revised.
REQ-034 SHALL use 8-bit Idx arithmetic; no wrap past PMP_ENTRIES-1 is possible per REQ-024.

Reset
REQ-035 SHALL, while resetn=0 and regardless of clk, force state=IDLE, Idx=0, PrevGE=1, RespValid=0, Fault=0, MatchFound=0, MatchIdx=0, ReqReady=1.
REQ-036 SHALL, on reset asserted mid-SCAN or mid-RESP, discard the in-flight request with no response.

Verification
REQ-037 SHALL cover: all cfg=0, U-mode read 0x8000_0000 -> RespValid after 16 edges, MatchFound=0, Fault=1.
REQ-038 SHALL cover: entry 2 NAPOT pmpaddr=0x2000_0FFF, cfg R only, S-mode read 0x8000_1000 -> MatchIdx=2 after 3 edges, Fault=0; the same with write -> Fault=1.
REQ-039 SHALL cover: entry0 TOR addr 0x1000>>2, entry1 TOR addr 0x2000>>2 with X set, U-mode fetch at 0x1800 -> MatchIdx=1, Fault=0; fetch at 0x2000 -> no entry-1 match.
REQ-040 SHALL cover: M-mode write matching entry 0 with L=1 and W=0 -> Fault=1; the same with L=0 -> Fault=0.
REQ-041 SHALL cover: CfgWrite at scan Idx=5 -> RespValid delayed by 6 cycles, result computed from the new cfg.
REQ-042 SHALL cover: RespReady held 0 for 10 cycles -> outputs stable, ReqReady=0; resetn pulsed mid-SCAN -> RespValid=0 and ReqReady=1 immediately.

Source files
------------

// File: rtl/pmp_scan_ctrl.sv
// pmp_scan_ctrl: sequential PMP checker, one entry per cycle through a shared matcher.
// First match wins; CSR writes during a scan restart it from entry 0.
module pmp_scan_ctrl #(
  parameter int PMP_ENTRIES = 16,
  parameter int PA_BITS     = 56
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               ReqValid,
  output logic                               ReqReady,
  input  logic [PA_BITS-1:0]                 PhysicalAddress,
  input  logic [1:0]                         PrivilegeMode,
  input  logic [2:0]                         AccessXWR,
  input  logic [8*PMP_ENTRIES-1:0]           PMPCFG_ARRAY_REGW,
  input  logic [(PA_BITS-2)*PMP_ENTRIES-1:0] PMPADDR_ARRAY_REGW,
  input  logic                               CfgWrite,
  output logic                               RespValid,
  input  logic                               RespReady,
  output logic                               Fault,
  output logic                               MatchFound,
  output logic [5:0]                         MatchIdx
);
  localparam int N1 = PMP_ENTRIES > 0 ? PMP_ENTRIES : 1;
  localparam int IW = N1 > 1 ? $clog2(N1) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t               state;
  logic [7:0]           idx;
  logic                 prev_ge;
  logic [PA_BITS-1:0]   pa;
  logic [1:0]           priv;
  logic [2:0]           xwr;
  // compacted cfg: {L, A[1:0], X, W, R}
  logic [5:0]           cfg  [N1];
  logic [PA_BITS-3:0]   addr [N1];
  logic [5:0]           c;
  logic [PA_BITS-3:0]   a;
  logic [PA_BITS-3:0]   nmask;
  logic                 ge, match, last, f_hit, f_miss;
  genvar i;
  if (PMP_ENTRIES == 0) begin : g_none
    assign cfg[0]  = '0;
    assign addr[0] = '0;
  end else begin : g_ent
    for (i = 0; i < PMP_ENTRIES; i++) begin : g_e
      logic unused_rsv;
      assign unused_rsv = ^PMPCFG_ARRAY_REGW[8*i+5 +: 2];
      assign cfg[i]  = {PMPCFG_ARRAY_REGW[8*i+7], PMPCFG_ARRAY_REGW[8*i +: 5]};
      assign addr[i] = PMPADDR_ARRAY_REGW[(PA_BITS-2)*i +: PA_BITS-2];
    end
  end
  assign ReqReady = (state == IDLE);
  always_comb begin
    c      = cfg[idx[IW-1:0]];
    a      = addr[idx[IW-1:0]];
    ge     = pa >= {a, 2'b00};
    // ones over the trailing-ones run plus the first zero: the don't-care NAPOT bits
    nmask  = a ^ (a + 1'b1);
    match  = c[4:3] == 2'd1 ? prev_ge & ~ge :
             c[4:3] == 2'd2 ? pa[PA_BITS-1:2] == a :
             c[4:3] == 2'd3 ? ((pa[PA_BITS-1:2] ^ a) & ~nmask) == '0 : 1'b0;
    last   = (PMP_ENTRIES == 0) ? 1'b1 : idx == 8'(PMP_ENTRIES - 1);
    f_hit  = ((priv != 2'd3) | c[5]) & |(xwr & ~c[2:0]);
    f_miss = (priv != 2'd3) & |xwr;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= '0;
      prev_ge    <= 1'b1;
      pa         <= '0;
      priv       <= '0;
      xwr        <= '0;
      RespValid  <= 1'b0;
      Fault      <= 1'b0;
      MatchFound <= 1'b0;
      MatchIdx   <= '0;
    end else begin
      case (state)
        IDLE: if (ReqValid) begin
          pa      <= PhysicalAddress;
          priv    <= PrivilegeMode;
          xwr     <= AccessXWR;
          idx     <= '0;
          prev_ge <= 1'b1;
          state   <= SCAN;
        end
        SCAN: if (CfgWrite) begin
          idx     <= '0;
          prev_ge <= 1'b1;
        end else begin
          prev_ge <= ge;
          if (match | last) begin
            state      <= RESP;
            RespValid  <= 1'b1;
            MatchFound <= match;
            MatchIdx   <= match ? idx[5:0] : 6'd0;
            Fault      <= match ? f_hit : f_miss;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        RESP: if (RespReady) begin
          state     <= IDLE;
          RespValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// tb_pmp_scan_ctrl: directed checks of pmp_scan_ctrl with a queue of expected responses.
module tb_pmp_scan_ctrl;
  localparam int N  = 16;
  localparam int PA = 56;
  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 ReqValid, ReqReady;
  logic [PA-1:0]        PhysicalAddress;
  logic [1:0]           PrivilegeMode;
  logic [2:0]           AccessXWR;
  logic [8*N-1:0]       cfg;
  logic [(PA-2)*N-1:0]  addr;
  logic                 CfgWrite, RespValid, RespReady, Fault, MatchFound;
  logic [5:0]           MatchIdx;
  typedef struct {logic f; logic mf; logic [5:0] idx; int lat;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0, n = 0;
  pmp_scan_ctrl #(.PMP_ENTRIES(N), .PA_BITS(PA)) dut (
    .clk(clk), .resetn(resetn), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .PhysicalAddress(PhysicalAddress), .PrivilegeMode(PrivilegeMode), .AccessXWR(AccessXWR),
    .PMPCFG_ARRAY_REGW(cfg), .PMPADDR_ARRAY_REGW(addr), .CfgWrite(CfgWrite),
    .RespValid(RespValid), .RespReady(RespReady), .Fault(Fault),
    .MatchFound(MatchFound), .MatchIdx(MatchIdx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
    n++;
  endtask
  task automatic clr();
    cfg  = '0;
    addr = '0;
  endtask
  task automatic set_ent(input int i, input logic [7:0] c, input logic [PA-3:0] a);
    cfg[8*i +: 8]       = c;
    addr[(PA-2)*i +: PA-2] = a;
  endtask
  task automatic start_req(input string tag, input logic [PA-1:0] p, input logic [1:0] pm,
                           input logic [2:0] x, input logic f, input logic mf,
                           input logic [5:0] ix, input int lat);
    q.push_back('{f: f, mf: mf, idx: ix, lat: lat});
    PhysicalAddress = p;
    PrivilegeMode   = pm;
    AccessXWR       = x;
    ReqValid        = 1'b1;
    chk({tag, "_ready"}, 64'(ReqReady), 64'd1);
    @(posedge clk); #1;
    ReqValid = 1'b0;
    n = 0;
  endtask
  task automatic wait_resp(input string tag);
    while (!RespValid && n < 40) tick();
    e = q.pop_front();
    chk({tag, "_valid"}, 64'(RespValid), 64'd1);
    chk({tag, "_lat"}, 64'(n), 64'(e.lat));
    chk({tag, "_fault"}, 64'(Fault), 64'(e.f));
    chk({tag, "_match"}, 64'(MatchFound), 64'(e.mf));
    chk({tag, "_idx"}, 64'(MatchIdx), 64'(e.idx));
  endtask
  task automatic ack(input string tag);
    RespReady = 1'b1;
    @(posedge clk); #1;
    RespReady = 1'b0;
    chk({tag, "_idle"}, {62'd0, RespValid, ReqReady}, 64'b01);
  endtask
  task automatic req(input string tag, input logic [PA-1:0] p, input logic [1:0] pm,
                     input logic [2:0] x, input logic f, input logic mf,
                     input logic [5:0] ix, input int lat);
    start_req(tag, p, pm, x, f, mf, ix, lat);
    wait_resp(tag);
    ack(tag);
  endtask
  initial begin
    int bad;
    resetn = 1'b0; ReqValid = 1'b0; CfgWrite = 1'b0; RespReady = 1'b0;
    PhysicalAddress = '0; PrivilegeMode = '0; AccessXWR = '0;
    clr();
    #2;
    chk("rst_outs", {57'd0, ReqReady, RespValid, Fault, MatchFound, MatchIdx != 6'd0}, {57'd0, 5'b10000});
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    // no entries enabled: U-mode read walks all 16 and faults
    req("allOff", 56'h8000_0000, 2'd0, 3'b001, 1'b1, 1'b0, 6'd0, 16);
    // NAPOT 32 KiB at 0x8000_0000 on entry 2, read-only
    set_ent(2, 8'h19, 54'h2000_0FFF);
    req("napotR", 56'h8000_1000, 2'd1, 3'b001, 1'b0, 1'b1, 6'd2, 3);
    req("napotW", 56'h8000_1000, 2'd1, 3'b010, 1'b1, 1'b1, 6'd2, 3);
    req("napotOut", 56'h8000_8000, 2'd1, 3'b001, 1'b1, 1'b0, 6'd0, 16);
    clr();
    set_ent(0, 8'h08, 54'h400);
    set_ent(1, 8'h0C, 54'h800);
    req("torIn", 56'h1800, 2'd0, 3'b100, 1'b0, 1'b1, 6'd1, 2);
    req("torEdge", 56'h2000, 2'd0, 3'b100, 1'b1, 1'b0, 6'd0, 16);
    req("torLow", 56'h0800, 2'd0, 3'b100, 1'b1, 1'b1, 6'd0, 1);
    req("noAccess", 56'h2000, 2'd0, 3'b000, 1'b0, 1'b0, 6'd0, 16);
    clr();
    set_ent(0, 8'h91, 54'h400);
    req("mLocked", 56'h1000, 2'd3, 3'b010, 1'b1, 1'b1, 6'd0, 1);
    set_ent(0, 8'h11, 54'h400);
    req("mUnlocked", 56'h1000, 2'd3, 3'b010, 1'b0, 1'b1, 6'd0, 1);
    req("mMiss", 56'h5000, 2'd3, 3'b111, 1'b0, 1'b0, 6'd0, 16);
    // CSR write while entry 5 is being examined restarts the walk with the new table
    clr();
    start_req("cfgw", 56'h3000, 2'd0, 3'b001, 1'b0, 1'b1, 6'd3, 10);
    repeat (5) tick();
    CfgWrite = 1'b1;
    set_ent(3, 8'h11, 54'hC00);
    tick();
    CfgWrite = 1'b0;
    wait_resp("cfgw");
    // stall the consumer; CSR writes now must not revise the delivered result
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      CfgWrite = 1'b1;
      set_ent(3, 8'h00, 54'h0);
      tick();
      if ({RespValid, ReqReady, Fault, MatchFound, MatchIdx} !== {1'b1, 1'b0, 1'b0, 1'b1, 6'd3}) bad++;
    end
    CfgWrite = 1'b0;
    chk("holdStable", 64'(bad), 64'd0);
    ack("hold");
    // reset during a scan drops the request
    start_req("rstMid", 56'h8000_0000, 2'd0, 3'b001, 1'b1, 1'b0, 6'd0, 16);
    tick(); tick();
    resetn = 1'b0;
    #1;
    chk("rstMid_outs", {60'd0, RespValid, ReqReady, MatchFound, Fault}, {60'd0, 4'b0100});
    void'(q.pop_front());
    @(negedge clk); resetn = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (RespValid !== 1'b0 || ReqReady !== 1'b1) bad++;
    end
    chk("rstMid_noResp", 64'(bad), 64'd0);
    set_ent(4, 8'h1F, 54'h0000_0000_0FFF);
    req("afterRst", 56'h0000_2000, 2'd0, 3'b111, 1'b0, 1'b1, 6'd4, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
